// File: rtl/reset_source_pkg.sv
// Shared state/cause encodings and counter sizing for the reset source controller.
// Latency: n/a. Backpressure: n/a.
package reset_source_pkg;

    localparam int STATE_W = 2;
    localparam int CAUSE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_POR       = 2'd0,
        CAUSE_LOCK_LOSS = 2'd1,
        CAUSE_BUTTON    = 2'd2,
        CAUSE_TIMEOUT   = 2'd3
    } cause_t;

    // Bits needed for a counter that runs 0 .. cycles-1.
    function automatic int cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/reset_source_debounce.sv
// Push-button debouncer: output follows input once it has differed for DEBOUNCE_CYCLES cycles.
// Latency: DEBOUNCE_CYCLES cycles after a stable change. Backpressure: none, free-running.
module reset_source_debounce
    import reset_source_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
)(
    input  logic clock,
    input  logic areset,
    input  logic din,
    output logic dout
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Any sample equal to the accepted level restarts the stability window.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            dout <= din;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reset_source_ctrl.sv
// Board reset sequencer: PLL reset, lock wait, lock hold, run; optional lock timeout via RESET_SOURCE_LOCK_TIMEOUT_EN.
// Latency: 2-cycle input sync, outputs registered on the state-change edge. Backpressure: none.
module reset_source_ctrl
    import reset_source_pkg::*;
#(
    parameter int N_PLL               = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int HOLD_CYCLES         = 1024,
    parameter int DEBOUNCE_CYCLES     = 65536,
    parameter int LOCK_TIMEOUT_CYCLES = 1048576
)(
    input  logic               clock,
    input  logic               areset,
    input  logic               button,
    input  logic [N_PLL-1:0]   pll_locked,
    output logic               pll_reset,
    output logic               sys_areset,
    output logic [STATE_W-1:0] state,
    output logic [CAUSE_W-1:0] cause
);

    localparam int RW = cnt_w(PLL_RST_CYCLES);
    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam logic [RW-1:0] RST_LAST  = RW'(PLL_RST_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t cur_state, next_state;
    cause_t cur_cause, next_cause;

    logic             btn_meta, btn_sync, btn_db, btn_db_q;
    logic [N_PLL-1:0] lock_meta, lock_sync;
    logic             all_locked, btn_rise;
    logic [RW-1:0]    rst_cnt;
    logic [HW-1:0]    hold_cnt;
    logic             rst_done, hold_done;

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            lock_meta <= '0;
            lock_sync <= '0;
        end else begin
            btn_meta  <= button;
            btn_sync  <= btn_meta;
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    assign all_locked = &lock_sync;

    reset_source_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .areset (areset),
        .din    (btn_sync),
        .dout   (btn_db)
    );

    assign btn_rise  = btn_db & ~btn_db_q;
    assign rst_done  = (rst_cnt == RST_LAST);
    assign hold_done = (hold_cnt == HOLD_LAST);

`ifdef RESET_SOURCE_LOCK_TIMEOUT_EN
    localparam int TW = cnt_w(LOCK_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt;
    logic          to_done;

    assign to_done = (to_cnt == TO_LAST);

    always_ff @(posedge clock or posedge areset) begin
        if (areset)                         to_cnt <= '0;
        else if (cur_state != ST_WAIT_LOCK) to_cnt <= '0;
        else if (!to_done)                  to_cnt <= to_cnt + TW'(1);
    end
`else
    // Timeout disabled in this build; parameter kept so both builds share one interface.
    localparam int unused_lock_timeout = LOCK_TIMEOUT_CYCLES;
`endif

    // Button events are tested before lock events so they win on a tie.
    always_comb begin
        next_state = cur_state;
        next_cause = cur_cause;
        case (cur_state)
            ST_RESET: begin
                if (rst_done && !btn_db) next_state = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (btn_db) begin
                    next_state = ST_RESET;
                    next_cause = CAUSE_BUTTON;
                end else if (all_locked) begin
                    next_state = ST_HOLD;
                end
`ifdef RESET_SOURCE_LOCK_TIMEOUT_EN
                else if (to_done) begin
                    next_state = ST_RESET;
                    next_cause = CAUSE_TIMEOUT;
                end
`endif
            end
            ST_HOLD: begin
                if (btn_db) begin
                    next_state = ST_RESET;
                    next_cause = CAUSE_BUTTON;
                end else if (!all_locked) begin
                    next_state = ST_WAIT_LOCK;
                end else if (hold_done) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (btn_rise) begin
                    next_state = ST_RESET;
                    next_cause = CAUSE_BUTTON;
                end else if (!all_locked) begin
                    next_state = ST_WAIT_LOCK;
                    next_cause = CAUSE_LOCK_LOSS;
                end
            end
        endcase
    end

    // Counters clear while outside their state, so each visit starts from zero.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            cur_state  <= ST_RESET;
            cur_cause  <= CAUSE_POR;
            pll_reset  <= 1'b1;
            sys_areset <= 1'b1;
            btn_db_q   <= 1'b0;
            rst_cnt    <= '0;
            hold_cnt   <= '0;
        end else begin
            cur_state  <= next_state;
            cur_cause  <= next_cause;
            pll_reset  <= (next_state == ST_RESET);
            sys_areset <= (next_state != ST_RUN);
            btn_db_q   <= btn_db;

            if (cur_state != ST_RESET) rst_cnt <= '0;
            else if (!rst_done)        rst_cnt <= rst_cnt + RW'(1);

            if (cur_state != ST_HOLD)        hold_cnt <= '0;
            else if (all_locked && !hold_done) hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign state = cur_state;
    assign cause = cur_cause;

endmodule
